composition_cursor_ctrl: RTL and testbench

- Editor front end of the composition datapath. Sits directly upstream of the note decoder.
- Converts debounced, synchronised user buttons into the decoder's edit interface: cursor position, selected note, write index, and single-cycle place/delete strobes.
- Tracks slot occupancy so it can report how many notes the composition holds.
- Auto-repeats cursor/note movement while a direction button is held.

---
 rtl/composition_cursor_ctrl.sv | 85 ++++++++
 tb/tb_composition_cursor_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/composition_cursor_ctrl.sv
// composition_cursor_ctrl: turns debounced buttons into cursor/note movement and place/delete strobes,
// tracks slot occupancy, and auto-repeats held direction buttons.
module composition_cursor_ctrl #(
   parameter int NUM_POS       = 64,
   parameter int NUM_NOTES     = 64,
   parameter int HOLD_DELAY    = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_place,
   input  logic       btn_delete,
   output logic [5:0] curr_pos,
   output logic [5:0] curr_note,
   output logic [5:0] i_note,
   output logic       place,
   output logic       delete,
   output logic [6:0] note_count
);
   localparam int CW = $clog2(HOLD_DELAY + 1);
   localparam logic [5:0] LAST_POS = 6'(NUM_POS - 1);
   localparam logic [5:0] LAST_NOTE = 6'(NUM_NOTES - 1);
   localparam logic [CW-1:0] RELOAD = CW'(HOLD_DELAY - REPEAT_PERIOD + 1);
   typedef enum logic [1:0] {IDLE, COMMIT, ADVANCE} state_t;
   state_t state;
   logic [5:0] hist, btn, pr;
   logic [3:0] dir, mv;
   logic [CW-1:0] cnt;
   logic [NUM_POS-1:0] occ;
   logic armed, start, rep_ok, rep_fire;
   // armed masks the first cycle after reset so buttons held through reset are not seen as presses
   always_comb begin
      btn = {btn_delete, btn_place, btn_left, btn_right, btn_up, btn_down};
      pr = armed ? btn & ~hist : '0;
      dir = btn[3:0];
      start = state == IDLE && pr[5:4] == '0 && $onehot(dir) && pr[3:0] == dir;
      rep_ok = state == IDLE && cnt != '0 && $onehot(dir) && (dir & hist[3:0]) == dir && pr == '0;
      rep_fire = rep_ok && cnt == CW'(HOLD_DELAY);
      mv = pr != '0 ? {pr[3] & ~pr[2], pr[2] & ~pr[3], pr[1] & ~pr[0], pr[0] & ~pr[1]} : rep_fire ? dir : '0;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         hist <= '0;
         armed <= 1'b0;
         cnt <= '0;
         occ <= '0;
         curr_pos <= '0;
         curr_note <= '0;
         i_note <= '0;
         place <= 1'b0;
         delete <= 1'b0;
         note_count <= '0;
      end else begin
         hist <= btn;
         armed <= 1'b1;
         place <= 1'b0;
         delete <= 1'b0;
         cnt <= start ? CW'(1) : rep_fire ? RELOAD : rep_ok ? cnt + CW'(1) : '0;
         if (state == COMMIT) begin
            state <= place ? ADVANCE : IDLE;
            if (place && curr_pos != LAST_POS) curr_pos <= curr_pos + 6'd1;
         end else if (state == ADVANCE) state <= IDLE;
         else if (pr[5]) begin
            delete <= 1'b1;
            i_note <= curr_pos;
            occ[curr_pos] <= 1'b0;
            if (occ[curr_pos]) note_count <= note_count - 7'd1;
            state <= COMMIT;
         end else if (pr[4]) begin
            place <= 1'b1;
            i_note <= curr_pos;
            occ[curr_pos] <= 1'b1;
            if (!occ[curr_pos]) note_count <= note_count + 7'd1;
            state <= COMMIT;
         end else if (mv[3]) curr_pos <= curr_pos == '0 ? '0 : curr_pos - 6'd1;
         else if (mv[2]) curr_pos <= curr_pos == LAST_POS ? LAST_POS : curr_pos + 6'd1;
         else if (mv[1]) curr_note <= curr_note == LAST_NOTE ? '0 : curr_note + 6'd1;
         else if (mv[0]) curr_note <= curr_note == '0 ? LAST_NOTE : curr_note - 6'd1;
      end
endmodule

// File: tb/tb_composition_cursor_ctrl.sv
// tb_composition_cursor_ctrl: vector table for edits plus hand sequences for reset, saturation and auto-repeat;
// place/delete strobes are checked against a queue of expected writes.
module tb_composition_cursor_ctrl;
   localparam logic [5:0] D = 6'b100000, P = 6'b010000, L = 6'b001000, R = 6'b000100, U = 6'b000010, N = 6'b000001;
   logic clk = 1'b0, reset_n = 1'b0;
   logic [5:0] btns = '0;
   logic [5:0] curr_pos, curr_note, i_note;
   logic place, delete;
   logic [6:0] note_count;
   int errors = 0, checks = 0;
   typedef struct {logic [5:0] b; int pos; int note; int cnt; int strobe;} vec_t;
   typedef struct {bit del; int idx;} sb_t;
   vec_t vt[$];
   sb_t exp_q[$];

   always #5 clk = ~clk;

   composition_cursor_ctrl #(.HOLD_DELAY(10), .REPEAT_PERIOD(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .btn_left(btns[3]), .btn_right(btns[2]), .btn_up(btns[1]), .btn_down(btns[0]),
      .btn_place(btns[4]), .btn_delete(btns[5]),
      .curr_pos(curr_pos), .curr_note(curr_note), .i_note(i_note),
      .place(place), .delete(delete), .note_count(note_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic [5:0] b, input int pos, input int note, input int cnt, input int s);
      vec_t v;
      v.b = b; v.pos = pos; v.note = note; v.cnt = cnt; v.strobe = s;
      vt.push_back(v);
   endtask

   task automatic pulse(input logic [5:0] b, input int gap);
      btns = b;
      @(posedge clk);
      #1 btns = '0;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic expect_strobe(input bit del, input int idx);
      sb_t e;
      e.del = del; e.idx = idx;
      exp_q.push_back(e);
   endtask

   // every strobe seen must match the oldest expected write; extra strobes fail
   always @(negedge clk)
      if (reset_n && (place || delete)) begin
         sb_t e;
         if (place && delete) chk("place_and_delete_together", 1, 0);
         if (exp_q.size() == 0) chk("unexpected_strobe", place ? 1 : 2, 0);
         else begin
            e = exp_q.pop_front();
            chk("strobe_kind_is_delete", delete, e.del);
            chk("strobe_i_note", i_note, e.idx);
         end
      end

   initial begin
      int pp;
      btns = 6'h3F;
      repeat (3) @(posedge clk);
      #1;
      chk("reset curr_pos", curr_pos, 0);
      chk("reset curr_note", curr_note, 0);
      chk("reset i_note", i_note, 0);
      chk("reset place", place, 0);
      chk("reset delete", delete, 0);
      chk("reset note_count", note_count, 0);
      reset_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("held after reset curr_pos", curr_pos, 0);
      chk("held after reset curr_note", curr_note, 0);
      chk("held after reset note_count", note_count, 0);
      btns = '0;
      repeat (2) @(posedge clk);
      #1;

      add(R, 1, 0, 0, 0); add(R, 2, 0, 0, 0); add(R, 3, 0, 0, 0);
      add(L, 2, 0, 0, 0); add(L, 1, 0, 0, 0); add(L, 0, 0, 0, 0); add(L, 0, 0, 0, 0); add(L, 0, 0, 0, 0);
      add(N, 0, 63, 0, 0); add(U, 0, 0, 0, 0);
      add(U, 0, 1, 0, 0); add(U, 0, 2, 0, 0); add(U, 0, 3, 0, 0); add(U, 0, 4, 0, 0); add(U, 0, 5, 0, 0);
      add(R, 1, 5, 0, 0); add(R, 2, 5, 0, 0);
      add(P, 3, 5, 1, 1); add(L, 2, 5, 1, 0); add(P, 3, 5, 1, 1); add(L, 2, 5, 1, 0);
      add(D, 2, 5, 0, 2); add(D, 2, 5, 0, 2); add(P | D, 2, 5, 0, 2);
      add(L | R, 2, 5, 0, 0); add(U | N, 2, 5, 0, 0);
      pp = 0;
      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].strobe != 0) expect_strobe(vt[i].strobe == 2, pp);
         pulse(vt[i].b, 5);
         chk($sformatf("vec%0d curr_pos", i), curr_pos, vt[i].pos);
         chk($sformatf("vec%0d curr_note", i), curr_note, vt[i].note);
         chk($sformatf("vec%0d note_count", i), note_count, vt[i].cnt);
         pp = vt[i].pos;
      end

      repeat (70) pulse(R, 2);
      chk("right saturates at 63", curr_pos, 63);
      expect_strobe(1'b0, 63);
      pulse(P, 5);
      chk("place at 63 no advance", curr_pos, 63);
      chk("place at 63 note_count", note_count, 1);
      repeat (70) pulse(L, 2);
      chk("left back to 0", curr_pos, 0);
      chk("i_note held while idle", i_note, 63);

      btns = R;
      repeat (10) @(posedge clk);
      #1;
      chk("repeat before hold delay", curr_pos, 1);
      @(posedge clk);
      #1;
      chk("first repeat step", curr_pos, 2);
      repeat (19) @(posedge clk);
      #1 btns = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("auto-repeat final curr_pos", curr_pos, 6);
      chk("auto-repeat curr_note unchanged", curr_note, 5);

      btns = P;
      @(posedge clk);
      #1 btns = '0;
      chk("place strobe before reset", place, 1);
      reset_n = 1'b0;
      #1;
      chk("mid-commit reset place", place, 0);
      chk("mid-commit reset curr_pos", curr_pos, 0);
      chk("mid-commit reset note_count", note_count, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("no strobe after reset", place | delete, 0);
      chk("scoreboard drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
